// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request; sampled only while idle
//   dividend     numerator, captured on accept
//   divisor      denominator, captured on accept
//   busy         high while a division is in progress
//   done         one-cycle pulse: quotient/remainder/div_by_zero valid
//   quotient     registered quotient, held until next completion
//   remainder    registered remainder, held until next completion
//   div_by_zero  set with done when the divisor was zero
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StCalc} state_t;

  state_t          state;
  // Holds the unconsumed dividend bits in the top and collects quotient bits
  // in the bottom; after WIDTH shifts it contains the whole quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  // A restored remainder is always < divisor, so WIDTH bits suffice between
  // iterations; the extra bit only exists in the shifted trial value.
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;

  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    q_bit    = (trial >= {1'b0, dvs_q});
    rem_next = trial[WIDTH-1:0];
    if (q_bit) begin
      rem_next = WIDTH'(trial - {1'b0, dvs_q});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            if (divisor != '0) begin
              rem_q <= '0;
              cnt_q <= CntW'(WIDTH);
              busy  <= 1'b1;
              state <= StCalc;
            end else begin
              // Divide by zero resolves immediately without entering CALC.
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
            end
          end
        end
        StCalc: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quotient    <= {dvd_q[WIDTH-2:0], q_bit};
            remainder   <= rem_next;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [3:0] a, input logic [3:0] b);
    vec_t v;
    v.a   = a;
    v.b   = b;
    v.dbz = (b == 0);
    v.q   = (b == 0) ? 4'hF : 4'(a / b);
    v.r   = (b == 0) ? a : 4'(a % b);
    return v;
  endfunction

  // Scoreboard: every done pulse pops the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      vec_t e;
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(1'b0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("result %0d/%0d", e.a, e.b),
            {23'b0, div_by_zero, quotient, remainder},
            {23'b0, e.dbz, e.q, e.r});
        if (e.b != 0) begin
          chk($sformatf("invariant %0d/%0d", e.a, e.b),
              32'((int'(e.a) == int'(quotient) * int'(e.b) + int'(remainder)) &&
                  (remainder < e.b)), 32'd1);
        end
      end
    end
  end

  // Issue one request from a negedge and wait (bounded) for its done pulse.
  task automatic run_one(input vec_t v);
    bit seen = 0;
    start    = 1'b1;
    dividend = v.a;
    divisor  = v.b;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  vec_t tbl[10];

  initial begin
    int base_done;

    tbl[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, dbz: 1'b0};
    tbl[1] = '{a: 4'd7,  b: 4'd0,  q: 4'hF,  r: 4'd7, dbz: 1'b1};
    tbl[2] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, dbz: 1'b0};
    tbl[3] = '{a: 4'd0,  b: 4'd5,  q: 4'd0,  r: 4'd0, dbz: 1'b0};
    tbl[4] = '{a: 4'd5,  b: 4'd15, q: 4'd0,  r: 4'd5, dbz: 1'b0};
    tbl[5] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, dbz: 1'b0};
    tbl[6] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  r: 4'd2, dbz: 1'b0};
    tbl[7] = '{a: 4'd14, b: 4'd4,  q: 4'd3,  r: 4'd2, dbz: 1'b0};
    tbl[8] = '{a: 4'd0,  b: 4'd0,  q: 4'hF,  r: 4'd0, dbz: 1'b1};
    tbl[9] = '{a: 4'd9,  b: 4'd2,  q: 4'd4,  r: 4'd1, dbz: 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {27'b0, busy, done, div_by_zero, 2'b0},        32'd0);
    chk("reset_results", {24'b0, quotient, remainder},                   32'd0);

    // 13/3 latency: busy for 4 cycles then done
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    sb.push_back(tbl[0]);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1 busy/done cycle %0d", i), {30'b0, busy, done}, 32'b10);
      @(negedge clk);
    end
    chk("t1 done cycle busy/done", {30'b0, busy, done}, 32'b01);
    @(negedge clk);
    chk("t1 done clears", 32'(done), 32'd0);

    // 7/0: done on the very next edge, busy never set
    start = 1'b1; dividend = 4'd7; divisor = 4'd0;
    sb.push_back(tbl[1]);
    @(negedge clk);
    start = 1'b0;
    chk("t2 busy/done", {30'b0, busy, done}, 32'b01);
    @(negedge clk);
    chk("t2 done clears", {30'b0, busy, done}, 32'b00);
    chk("t2 results held", {23'b0, div_by_zero, quotient, remainder}, {23'b0, 1'b1, 4'hF, 4'd7});

    // Table vectors
    for (int i = 2; i < 10; i++) run_one(tbl[i]);

    // Start ignored while busy, then accepted in the done cycle
    start = 1'b1; dividend = 4'd12; divisor = 4'd5;
    sb.push_back(tbl[6]);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("t4 first done", {27'b0, done, quotient}, {27'b0, 1'b1, 4'd2});
    start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    sb.push_back(tbl[9]);
    @(negedge clk);
    start = 1'b0;
    chk("t4 second accepted", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    chk("t4 second done after 5", {27'b0, done, quotient}, {27'b0, 1'b1, 4'd4});
    @(negedge clk);

    // Async reset mid-CALC aborts the operation
    start = 1'b1; dividend = 4'd13; divisor = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5 reset busy/done", {30'b0, busy, done}, 32'd0);
    chk("t5 reset results", {23'b0, div_by_zero, quotient, remainder}, 32'd0);
    #1 rst = 1'b0;
    begin
      bit any_done = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (done) any_done = 1;
      end
      chk("t5 no done after abort", 32'(any_done), 32'd0);
    end
    run_one(tbl[9]);

    // Exhaustive back-to-back sweep
    base_done = n_done;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bit idle = 0;
        start    = 1'b1;
        dividend = 4'(a);
        divisor  = 4'(b);
        sb.push_back(model(4'(a), 4'(b)));
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
          if (!busy) begin
            idle = 1;
            break;
          end
          @(negedge clk);
        end
        if (!idle) chk("sweep busy timeout", 32'd0, 32'd1);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sweep done pulses", 32'(n_done - base_done), 32'd256);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
